// File: rtl/cm0_dap_cdc_recv_handshake.sv
// Receive end of a four-phase REQ/ACK CDC handshake: synchronise REQ, capture DATAIN, offer it
// with VALID/READY, then return a glitch-free ACK. Optional checker: CM0_DAP_CDC_RECV_PROTCHK_EN.
module cm0_dap_cdc_recv_handshake #(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          PRESENT     = 1'b1
) (
    input  logic          REGCLK,
    input  logic          REGRESETn,
    input  logic          SE,
    input  logic          REQ,
    input  logic [DW-1:0] DATAIN,
    output logic          ACK,
    output logic          VALID,
    input  logic          READY,
    output logic [DW-1:0] DATAOUT,
    output logic          PROTERR
);

    generate
        if (PRESENT) begin : g_present
            typedef enum logic [1:0] {StIdle, StHold, StAckH} state_e;

            state_e                 state_q;
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   req_s;
            logic                   ack_q;
            logic                   valid_q;
            logic [DW-1:0]          data_q;
            logic                   unused_se;

            assign unused_se = SE;

            always_ff @(posedge REGCLK or negedge REGRESETn) begin
                if (!REGRESETn) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], REQ};
                end
            end

            assign req_s = sync_q[SYNC_STAGES-1];

            // ACK and the data register are only written on the transitions that change them.
            always_ff @(posedge REGCLK or negedge REGRESETn) begin
                if (!REGRESETn) begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (req_s) begin
                                data_q  <= DATAIN;
                                valid_q <= 1'b1;
                                state_q <= StHold;
                            end
                        end
                        StHold: begin
                            if (READY) begin
                                valid_q <= 1'b0;
                                ack_q   <= 1'b1;
                                state_q <= StAckH;
                            end
                        end
                        StAckH: begin
                            if (!req_s) begin
                                ack_q   <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                        end
                    endcase
                end
            end

            assign ACK     = ack_q;
            assign VALID   = valid_q;
            assign DATAOUT = data_q;

`ifdef CM0_DAP_CDC_RECV_PROTCHK_EN
            logic proterr_q;

            // Request withdrawn before we acknowledged: flag it, but still finish the transfer.
            always_ff @(posedge REGCLK or negedge REGRESETn) begin
                if (!REGRESETn) begin
                    proterr_q <= 1'b0;
                end else if ((state_q == StHold) && !req_s) begin
                    proterr_q <= 1'b1;
                end
            end

            assign PROTERR = proterr_q;
`else
            assign PROTERR = 1'b0;
`endif
        end else begin : g_absent
            logic unused_inputs;

            assign unused_inputs = ^{REGCLK, REGRESETn, SE, REQ, DATAIN, READY};
            assign ACK           = 1'b0;
            assign VALID         = 1'b0;
            assign DATAOUT       = '0;
            assign PROTERR       = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_recv_handshake.sv
// Bench for cm0_dap_cdc_recv_handshake: protocol-level model compared every cycle, plus
// hand-computed directed checks; a PRESENT=0 instance shares the stimulus.
module tb_cm0_dap_cdc_recv_handshake;
    localparam int unsigned DW = 32;
    localparam int unsigned SS = 2;
`ifdef CM0_DAP_CDC_RECV_PROTCHK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          se    = 1'b0;
    logic          req   = 1'b0;
    logic          ready = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          ack, valid, proterr;
    logic [DW-1:0] dout;
    logic          ack0, valid0, proterr0;
    logic [DW-1:0] dout0;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] beats[$];

    // Protocol model: observable outputs only, plus REQ delayed through SS sampling edges.
    logic [SS-1:0] m_pipe  = '0;
    logic          m_valid = 1'b0;
    logic          m_ack   = 1'b0;
    logic          m_err   = 1'b0;
    logic [DW-1:0] m_data  = '0;

    always #5 clk = ~clk;

    cm0_dap_cdc_recv_handshake #(.DW(DW), .SYNC_STAGES(SS), .PRESENT(1'b1)) dut (
        .REGCLK(clk), .REGRESETn(rst_n), .SE(se), .REQ(req), .DATAIN(din),
        .ACK(ack), .VALID(valid), .READY(ready), .DATAOUT(dout), .PROTERR(proterr)
    );

    cm0_dap_cdc_recv_handshake #(.DW(DW), .SYNC_STAGES(SS), .PRESENT(1'b0)) dut_absent (
        .REGCLK(clk), .REGRESETn(rst_n), .SE(se), .REQ(req), .DATAIN(din),
        .ACK(ack0), .VALID(valid0), .READY(ready), .DATAOUT(dout0), .PROTERR(proterr0)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Bounded wait for VALID (sel=0) or ACK (sel=1) to reach val.
    task automatic wait_for(input string nm, input bit sel, input logic val);
        int i = 0;
        while (((sel ? ack : valid) !== val) && i < 40) begin
            step();
            i++;
        end
        check(nm, 64'(i < 40), 64'd1);
    endtask

    initial begin : model
        logic rs;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pipe  = '0;
                m_valid = 1'b0;
                m_ack   = 1'b0;
                m_err   = 1'b0;
                m_data  = '0;
            end else begin
                rs = m_pipe[SS-1];
                if (PCHK && m_valid && !rs) m_err = 1'b1;
                if (!m_valid && !m_ack && rs) begin
                    m_valid = 1'b1;
                    m_data  = din;
                end else if (m_valid && ready) begin
                    m_valid = 1'b0;
                    m_ack   = 1'b1;
                end else if (m_ack && !rs) begin
                    m_ack = 1'b0;
                end
                m_pipe = {m_pipe[SS-2:0], req};
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("ack_vs_model", 64'(ack), 64'(m_ack));
            check("valid_vs_model", 64'(valid), 64'(m_valid));
            check("dataout_vs_model", 64'(dout), 64'(m_data));
            check("proterr_vs_model", 64'(proterr), 64'(m_err));
            check("absent_outputs", 64'({ack0, valid0, proterr0}), 64'd0);
            check("absent_dataout", 64'(dout0), 64'd0);
            if (valid && ready) beats.push_back(dout);
        end
    end

    initial begin : stim
        // Reset state
        step(2);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_dataout", 64'(dout), 64'd0);
        check("rst_proterr", 64'(proterr), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Basic transfer: VALID on the third edge after REQ rises
        din = 32'hA5A5_1234; ready = 1'b1; req = 1'b1;
        step(2);
        check("basic_valid_early", 64'(valid), 64'd0);
        step();
        check("basic_valid", 64'(valid), 64'd1);
        check("basic_data", 64'(dout), 64'hA5A5_1234);
        check("basic_ack_low", 64'(ack), 64'd0);
        step();
        check("basic_ack", 64'(ack), 64'd1);
        check("basic_valid_drop", 64'(valid), 64'd0);
        step(3);
        check("basic_ack_hold", 64'(ack), 64'd1);
        req = 1'b0;
        step(2);
        check("basic_ack_still", 64'(ack), 64'd1);
        step();
        check("basic_ack_fall", 64'(ack), 64'd0);
        check("basic_data_kept", 64'(dout), 64'hA5A5_1234);

        // Backpressure
        ready = 1'b0; din = 32'h0BAD_F00D; req = 1'b1;
        wait_for("bp_wait_valid", 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 64'(valid), 64'd1);
            check("bp_ack", 64'(ack), 64'd0);
            check("bp_data", 64'(dout), 64'h0BAD_F00D);
        end
        ready = 1'b1;
        step();
        check("bp_ack_after", 64'(ack), 64'd1);
        check("bp_valid_after", 64'(valid), 64'd0);
        req = 1'b0;
        wait_for("bp_wait_ack_low", 1'b1, 1'b0);

        // Back-to-back 1, 2, 3; DATAIN scribbled while REQ is low
        beats.delete();
        for (int v = 1; v <= 3; v++) begin
            din = DW'(v); req = 1'b1;
            wait_for("b2b_wait_valid", 1'b0, 1'b1);
            wait_for("b2b_wait_ack", 1'b1, 1'b1);
            req = 1'b0; din = 32'hFFFF_0000 + DW'(v);
            wait_for("b2b_wait_ack_low", 1'b1, 1'b0);
        end
        step(2);
        check("b2b_beats", 64'(beats.size()), 64'd3);
        for (int i = 0; i < beats.size() && i < 3; i++) begin
            check("b2b_beat_data", 64'(beats[i]), 64'(i + 1));
        end
        check("b2b_data_kept", 64'(dout), 64'd3);

        // Request withdrawn during HOLD
        ready = 1'b0; din = 32'h1234_5678; req = 1'b1;
        wait_for("perr_wait_valid", 1'b0, 1'b1);
        req = 1'b0;
        step(3);
        check("perr_flag", 64'(proterr), 64'(PCHK));
        check("perr_valid_held", 64'(valid), 64'd1);
        step(2);
        check("perr_sticky", 64'(proterr), 64'(PCHK));
        ready = 1'b1;
        step();
        check("perr_ack", 64'(ack), 64'd1);
        step();
        check("perr_ack_fall", 64'(ack), 64'd0);
        check("perr_sticky2", 64'(proterr), 64'(PCHK));
        check("perr_data", 64'(dout), 64'h1234_5678);

        // Reset during HOLD, REQ left high -> recapture
        ready = 1'b0; din = 32'hCAFE_0001; req = 1'b1;
        wait_for("rh_wait_valid", 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rh_valid", 64'(valid), 64'd0);
        check("rh_data", 64'(dout), 64'd0);
        check("rh_ack", 64'(ack), 64'd0);
        check("rh_proterr", 64'(proterr), 64'd0);
        step();
        rst_n = 1'b1;
        step(2);
        check("rh_recap_early", 64'(valid), 64'd0);
        step();
        check("rh_recap_valid", 64'(valid), 64'd1);
        check("rh_recap_data", 64'(dout), 64'hCAFE_0001);

        // Reset during ACKH
        ready = 1'b1;
        wait_for("ra_wait_ack", 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ra_ack", 64'(ack), 64'd0);
        check("ra_valid", 64'(valid), 64'd0);
        check("ra_data", 64'(dout), 64'd0);
        step();
        rst_n = 1'b1;
        step(2);
        check("ra_recap_early", 64'(valid), 64'd0);
        step();
        check("ra_recap_valid", 64'(valid), 64'd1);
        check("ra_recap_data", 64'(dout), 64'hCAFE_0001);
        req = 1'b0;
        wait_for("ra_wait_ack_low", 1'b1, 1'b0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
